// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants shared by the UART-RX FSM, deserializer and parity checker
package uart_rx_pkg;
  typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} par_typ_e;
  localparam bit LSB_FIRST = 1'b0;
  localparam bit MSB_FIRST = 1'b1;
  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;
endpackage

// File: rtl/uart_rx_deser_gen_if.sv
// uart_rx_deser_gen_if: RX FSM / sampler to deserializer signal bundle
interface uart_rx_deser_gen_if #(
  parameter int DATA_W = 8,
  parameter int PRESCALE_W = 3
);
  logic frame_start;
  logic deser_en;
  logic sampled_bit;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic par_typ;
  logic [DATA_W-1:0] P_DATA;
  logic deser_done;
  logic par_calc;
  logic [3:0] bit_idx;
  logic overrun;
  modport master (
    output frame_start, deser_en, sampled_bit, edge_cnt, par_typ,
    input P_DATA, deser_done, par_calc, bit_idx, overrun
  );
  modport slave (
    input frame_start, deser_en, sampled_bit, edge_cnt, par_typ,
    output P_DATA, deser_done, par_calc, bit_idx, overrun
  );
endinterface

// File: rtl/uart_rx_deser_gen.sv
// uart_rx_deser_gen: shifts oversampled RX bits into a word, publishes it with parity and a done strobe
module uart_rx_deser_gen
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PRESCALE_W = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic CLK,
  input logic RST,
  uart_rx_deser_gen_if.slave bus
);
  logic [DATA_W-1:0] shift_q, shift_nxt;
  logic par_acc, cap, full, last;
  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
    $error("uart_rx_deser_gen: DATA_W must be within 5..9");
  end
  assign cap = bus.deser_en & (&bus.edge_cnt);
  assign full = bus.bit_idx == 4'(DATA_W);
  assign last = bus.bit_idx == 4'(DATA_W - 1);
  assign shift_nxt = (MSB_FIRST != LSB_FIRST) ? {shift_q[DATA_W-2:0], bus.sampled_bit}
                                              : {bus.sampled_bit, shift_q[DATA_W-1:1]};
  // frame_start outranks a coincident capture so a new frame always starts clean
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      shift_q <= '0;
      par_acc <= 1'b0;
      bus.bit_idx <= '0;
      bus.P_DATA <= '0;
      bus.deser_done <= 1'b0;
      bus.par_calc <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.deser_done <= 1'b0;
      if (bus.frame_start) begin
        shift_q <= '0;
        par_acc <= 1'b0;
        bus.bit_idx <= '0;
        bus.overrun <= 1'b0;
      end else if (cap && full) begin
        bus.overrun <= 1'b1;
      end else if (cap) begin
        shift_q <= shift_nxt;
        par_acc <= par_acc ^ bus.sampled_bit;
        bus.bit_idx <= bus.bit_idx + 4'd1;
        if (last) begin
          bus.P_DATA <= shift_nxt;
          bus.par_calc <= par_acc ^ bus.sampled_bit ^ bus.par_typ;
          bus.deser_done <= 1'b1;
        end
      end
    end
endmodule
